// File: rtl/ga_terminator.sv
// ga_terminator: watches evaluated chromosome pairs, keeps the best individual seen,
// counts generations and raises a sticky done on the generation limit or on stagnation.
module ga_terminator #(
    parameter int CHROM_W    = 8,
    parameter int FIT_W      = 27,
    parameter int POP_SIZE   = 16,
    parameter int MAX_GENS   = 64,
    parameter int STALL_GENS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [CHROM_W-1:0]      in_chrom1,
    input  logic [CHROM_W-1:0]      in_chrom2,
    input  logic signed [FIT_W-1:0] in_fit1,
    input  logic signed [FIT_W-1:0] in_fit2,
    output logic [CHROM_W-1:0]      best,
    output logic signed [FIT_W-1:0] best_fit,
    output logic [15:0]             gen_count,
    output logic                    busy,
    output logic                    done,
    output logic                    stalled
);

    localparam int PAIRS  = POP_SIZE / 2;
    localparam int PAIR_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [PAIR_W-1:0]      LAST_PAIR   = PAIR_W'(PAIRS - 1);
    localparam logic [15:0]            MAX_GEN_CNT = 16'(MAX_GENS);
    localparam logic [15:0]            STALL_LIMIT = 16'(STALL_GENS);
    localparam logic signed [FIT_W-1:0] FIT_MIN    = {1'b1, {(FIT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Signed "strictly better" test; ties never win.
    function automatic logic fit_greater(input logic signed [FIT_W-1:0] a,
                                         input logic signed [FIT_W-1:0] b);
        return a > b;
    endfunction

    state_t                  state;
    logic [PAIR_W-1:0]       pair_cnt;
    logic [15:0]             stall_cnt;
    logic                    improved;

    logic                    pick2_p0;
    logic [CHROM_W-1:0]      cand_chrom_p0;
    logic signed [FIT_W-1:0] cand_fit_p0;
    logic                    accept_p0;
    logic                    better_p0;
    logic                    last_pair_p0;
    logic                    gen_improved_p0;
    logic [15:0]             stall_next_p0;
    logic [15:0]             gen_next_p0;
    logic                    hit_max_p0;
    logic                    hit_stall_p0;

    // Stage p0: pick the pair winner and pre-compute the generation-boundary decision.
    always_comb begin
        pick2_p0        = fit_greater(in_fit2, in_fit1);
        cand_chrom_p0   = pick2_p0 ? in_chrom2 : in_chrom1;
        cand_fit_p0     = pick2_p0 ? in_fit2 : in_fit1;
        accept_p0       = (state == S_RUN) && in_valid && !start;
        better_p0       = fit_greater(cand_fit_p0, best_fit);
        last_pair_p0    = (pair_cnt == LAST_PAIR);
        gen_improved_p0 = improved || better_p0;
        stall_next_p0   = gen_improved_p0 ? 16'd0 : stall_cnt + 16'd1;
        gen_next_p0     = gen_count + 16'd1;
        hit_max_p0      = (gen_next_p0 == MAX_GEN_CNT);
        hit_stall_p0    = (stall_next_p0 == STALL_LIMIT);
    end

    // Stage p1: tracker, generation counter and FSM with registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            best      <= '0;
            best_fit  <= FIT_MIN;
            gen_count <= '0;
            pair_cnt  <= '0;
            stall_cnt <= '0;
            improved  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stalled   <= 1'b0;
        end else if (start) begin
            state     <= S_RUN;
            best      <= '0;
            best_fit  <= FIT_MIN;
            gen_count <= '0;
            pair_cnt  <= '0;
            stall_cnt <= '0;
            improved  <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            stalled   <= 1'b0;
        end else if (accept_p0) begin
            if (better_p0) begin
                best     <= cand_chrom_p0;
                best_fit <= cand_fit_p0;
            end
            if (last_pair_p0) begin
                pair_cnt  <= '0;
                gen_count <= gen_next_p0;
                improved  <= 1'b0;
                stall_cnt <= stall_next_p0;
                // The generation limit outranks stagnation when both land on one edge.
                if (hit_max_p0 || hit_stall_p0) begin
                    state   <= S_DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    stalled <= hit_stall_p0 && !hit_max_p0;
                end
            end else begin
                pair_cnt <= pair_cnt + PAIR_W'(1);
                improved <= gen_improved_p0;
            end
        end
    end

endmodule

// File: tb/tb_ga_terminator.sv
// Bench for ga_terminator: three instances with different limits share one stimulus stream
// and are compared against a history-based reference model.
module tb_ga_terminator;

    localparam int NI   = 3;
    localparam int POP  = 16;
    localparam int HMAX = 1100;
    localparam int FMIN = -(1 << 26);

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               in_valid;
    logic [7:0]         in_chrom1, in_chrom2;
    logic signed [26:0] in_fit1, in_fit2;

    logic [7:0]         o_best[NI];
    logic signed [26:0] o_fit[NI];
    logic [15:0]        o_gen[NI];
    logic               o_busy[NI], o_done[NI], o_stalled[NI];

    always #5 clk = ~clk;

    ga_terminator #(.CHROM_W(8), .FIT_W(27), .POP_SIZE(16), .MAX_GENS(64), .STALL_GENS(8)) dut_a (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_chrom1(in_chrom1), .in_chrom2(in_chrom2), .in_fit1(in_fit1), .in_fit2(in_fit2),
        .best(o_best[0]), .best_fit(o_fit[0]), .gen_count(o_gen[0]),
        .busy(o_busy[0]), .done(o_done[0]), .stalled(o_stalled[0]));

    ga_terminator #(.CHROM_W(8), .FIT_W(27), .POP_SIZE(16), .MAX_GENS(4), .STALL_GENS(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_chrom1(in_chrom1), .in_chrom2(in_chrom2), .in_fit1(in_fit1), .in_fit2(in_fit2),
        .best(o_best[1]), .best_fit(o_fit[1]), .gen_count(o_gen[1]),
        .busy(o_busy[1]), .done(o_done[1]), .stalled(o_stalled[1]));

    ga_terminator #(.CHROM_W(8), .FIT_W(27), .POP_SIZE(16), .MAX_GENS(4), .STALL_GENS(3)) dut_c (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_chrom1(in_chrom1), .in_chrom2(in_chrom2), .in_fit1(in_fit1), .in_fit2(in_fit2),
        .best(o_best[2]), .best_fit(o_fit[2]), .gen_count(o_gen[2]),
        .busy(o_busy[2]), .done(o_done[2]), .stalled(o_stalled[2]));

    // Reference model: the accepted individuals since the last start, in arrival order.
    int         h_fit[NI][HMAX];
    logic [7:0] h_chr[NI][HMAX];
    int         h_len[NI];
    bit         m_run[NI];

    logic [7:0] e_best[NI];
    int         e_fit[NI];
    int         e_gen[NI];
    bit         e_busy[NI], e_done[NI], e_stalled[NI];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int cfg_max(input int i);
        return (i == 0) ? 64 : 4;
    endfunction

    function automatic int cfg_stall(input int i);
        case (i)
            0:       return 8;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    // Replays the history: running maximum (first arrival wins ties), one generation per
    // POP individuals, a generation improves when its closing best beats its opening best.
    function automatic void model_eval(input int i);
        int         bf;
        logic [7:0] bc;
        int         prev;
        int         stall;
        int         gens;
        bit         dn;
        bit         st;
        bf = FMIN; bc = 8'h00; prev = FMIN; stall = 0; gens = 0; dn = 1'b0; st = 1'b0;
        for (int k = 0; k < h_len[i]; k++) begin
            if (h_fit[i][k] > bf) begin
                bf = h_fit[i][k];
                bc = h_chr[i][k];
            end
            if (k % POP == POP - 1) begin
                gens++;
                if (bf > prev) stall = 0;
                else stall++;
                prev = bf;
                if (gens == cfg_max(i)) dn = 1'b1;
                else if (stall == cfg_stall(i)) begin
                    dn = 1'b1;
                    st = 1'b1;
                end
            end
        end
        e_best[i]    = bc;
        e_fit[i]     = bf;
        e_gen[i]     = gens;
        e_done[i]    = dn;
        e_stalled[i] = st;
        e_busy[i]    = m_run[i] && !dn;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            m_run[i] = 1'b0;
            h_len[i] = 0;
        end
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < NI; i++) begin
            if (start) begin
                m_run[i] = 1'b1;
                h_len[i] = 0;
            end else if (in_valid) begin
                model_eval(i);
                if (e_busy[i] && h_len[i] + 2 <= HMAX) begin
                    h_fit[i][h_len[i]]     = int'(in_fit1);
                    h_chr[i][h_len[i]]     = in_chrom1;
                    h_fit[i][h_len[i] + 1] = int'(in_fit2);
                    h_chr[i][h_len[i] + 1] = in_chrom2;
                    h_len[i] += 2;
                end
            end
        end
    endfunction

    // Every stimulus task enters and leaves on a falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic send_pair(input logic [7:0] c1, input logic [7:0] c2, input int f1, input int f2);
        in_valid  = 1'b1;
        in_chrom1 = c1;
        in_chrom2 = c2;
        in_fit1   = 27'(f1);
        in_fit2   = 27'(f2);
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        in_chrom1 = '0; in_chrom2 = '0; in_fit1 = '0; in_fit2 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (o_best[i] !== 8'h00 || o_fit[i] !== 27'sh4000000 || o_gen[i] !== 16'd0 ||
                o_busy[i] !== 1'b0 || o_done[i] !== 1'b0 || o_stalled[i] !== 1'b0)
                $display("FAIL reset_state[%0d]: got best=%0h fit=%0h gen=%0d busy=%0b done=%0b stalled=%0b, want 0/4000000/0/0/0/0",
                         i, o_best[i], o_fit[i], o_gen[i], o_busy[i], o_done[i], o_stalled[i]);
            else n_pass++;
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_run();
        do_start();
        for (int p = 0; p < 10; p++) send_pair(8'(p + 1), 8'(p + 2), 20 + p, 10 - p);
        reset = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (o_best[i] !== 8'h00 || o_fit[i] !== 27'sh4000000 || o_gen[i] !== 16'd0 ||
                o_done[i] !== 1'b0 || o_busy[i] !== 1'b0)
                $display("FAIL async_reset[%0d]: got best=%0h fit=%0h gen=%0d done=%0b busy=%0b, want 0/4000000/0/0/0",
                         i, o_best[i], o_fit[i], o_gen[i], o_done[i], o_busy[i]);
            else n_pass++;
        end
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic test_first_gen();
        do_start();
        for (int k = 1; k <= 8; k++) begin
            send_pair(8'(16 + k), 8'(32 + k), k, -k);
            if (k == 1) begin
                n_checks++;
                if (o_fit[0] !== 27'sd1) $display("FAIL latency_fit: got %0d want 1", o_fit[0]);
                else n_pass++;
            end
        end
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (o_fit[i] !== 27'sd8 || o_best[i] !== 8'd24 || o_gen[i] !== 16'd1 ||
                o_busy[i] !== 1'b1 || o_done[i] !== 1'b0)
                $display("FAIL first_gen[%0d]: got fit=%0d best=%0d gen=%0d busy=%0b done=%0b, want 8/24/1/1/0",
                         i, o_fit[i], o_best[i], o_gen[i], o_busy[i], o_done[i]);
            else n_pass++;
        end
    endtask

    task automatic test_tie();
        do_start();
        send_pair(8'hAA, 8'h55, 5, 5);
        n_checks++;
        if (o_best[0] !== 8'hAA || o_fit[0] !== 27'sd5)
            $display("FAIL pair_tie: got best=%0h fit=%0d want aa/5", o_best[0], o_fit[0]);
        else n_pass++;
        send_pair(8'h11, 8'h22, 5, 5);
        send_pair(8'h33, 8'h44, 4, 5);
        n_checks++;
        if (o_best[0] !== 8'hAA || o_fit[0] !== 27'sd5)
            $display("FAIL incumbent_tie: got best=%0h fit=%0d want aa/5", o_best[0], o_fit[0]);
        else n_pass++;
    endtask

    task automatic test_stall();
        do_start();
        for (int p = 0; p < 8; p++) begin
            if (p == 3) send_pair(8'h07, 8'h64, 42, 100);
            else send_pair(8'($urandom), 8'($urandom), int'($urandom_range(0, 149)) - 50,
                           int'($urandom_range(0, 149)) - 50);
        end
        for (int p = 0; p < 64; p++) begin
            if (p == 63) begin
                n_checks++;
                if (o_done[0] !== 1'b0 || o_gen[0] !== 16'd8)
                    $display("FAIL stall_early: got done=%0b gen=%0d want 0/8", o_done[0], o_gen[0]);
                else n_pass++;
            end
            send_pair(8'($urandom), 8'($urandom), int'($urandom_range(0, 400)) - 300,
                      int'($urandom_range(0, 400)) - 300);
        end
        n_checks++;
        if (o_done[0] !== 1'b1 || o_stalled[0] !== 1'b1 || o_gen[0] !== 16'd9 ||
            o_fit[0] !== 27'sd100 || o_best[0] !== 8'h64 || o_busy[0] !== 1'b0)
            $display("FAIL stall_done: got done=%0b stalled=%0b gen=%0d fit=%0d best=%0h busy=%0b, want 1/1/9/100/64/0",
                     o_done[0], o_stalled[0], o_gen[0], o_fit[0], o_best[0], o_busy[0]);
        else n_pass++;
        for (int i = 1; i < NI; i++) begin
            n_checks++;
            if (o_done[i] !== 1'b1 || o_stalled[i] !== 1'b0 || o_gen[i] !== 16'd4 || o_fit[i] !== 27'sd100)
                $display("FAIL max_priority[%0d]: got done=%0b stalled=%0b gen=%0d fit=%0d, want 1/0/4/100",
                         i, o_done[i], o_stalled[i], o_gen[i], o_fit[i]);
            else n_pass++;
        end
    endtask

    task automatic test_max_gens();
        do_start();
        for (int p = 0; p < 32; p++) begin
            if (p == 31) begin
                n_checks++;
                if (o_done[1] !== 1'b0 || o_gen[1] !== 16'd3)
                    $display("FAIL max_early: got done=%0b gen=%0d want 0/3", o_done[1], o_gen[1]);
                else n_pass++;
            end
            send_pair(8'(p), 8'(p + 100), 10 * p, 10 * p + 5);
        end
        send_pair(8'hEE, 8'hEF, 1000, 0);
        for (int i = 1; i < NI; i++) begin
            n_checks++;
            if (o_done[i] !== 1'b1 || o_stalled[i] !== 1'b0 || o_gen[i] !== 16'd4 ||
                o_fit[i] !== 27'sd315 || o_best[i] !== 8'd131)
                $display("FAIL max_done[%0d]: got done=%0b stalled=%0b gen=%0d fit=%0d best=%0d, want 1/0/4/315/131",
                         i, o_done[i], o_stalled[i], o_gen[i], o_fit[i], o_best[i]);
            else n_pass++;
        end
        n_checks++;
        if (o_busy[0] !== 1'b1 || o_gen[0] !== 16'd4 || o_fit[0] !== 27'sd1000)
            $display("FAIL max_other: got busy=%0b gen=%0d fit=%0d want 1/4/1000", o_busy[0], o_gen[0], o_fit[0]);
        else n_pass++;
    endtask

    task automatic test_restart_in_done();
        in_valid = 1'b1; in_chrom1 = 8'h12; in_chrom2 = 8'h34; in_fit1 = 27'sd500; in_fit2 = 27'sd600;
        do_start();
        in_valid = 1'b0;
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (o_gen[i] !== 16'd0 || o_busy[i] !== 1'b1 || o_done[i] !== 1'b0 ||
                o_fit[i] !== 27'sh4000000 || o_best[i] !== 8'h00)
                $display("FAIL restart[%0d]: got gen=%0d busy=%0b done=%0b fit=%0h best=%0h, want 0/1/0/4000000/0",
                         i, o_gen[i], o_busy[i], o_done[i], o_fit[i], o_best[i]);
            else n_pass++;
        end
        reset = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        @(negedge clk);
        for (int p = 0; p < 10; p++) send_pair(8'hF0, 8'h0F, 77, 88);
        n_checks++;
        if (o_fit[0] !== 27'sh4000000 || o_gen[0] !== 16'd0 || o_busy[0] !== 1'b0 || o_best[0] !== 8'h00)
            $display("FAIL idle_ignore: got fit=%0h gen=%0d busy=%0b best=%0h, want 4000000/0/0/0",
                     o_fit[0], o_gen[0], o_busy[0], o_best[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        int base;
        int f1, f2;
        int bad;
        bad = 0;
        for (int phase = 0; phase < 2; phase++) begin
            base = 0;
            do_start();
            for (int cyc = 0; cyc < 1300; cyc++) begin
                start    = (phase == 1) && ($urandom_range(0, 299) == 0);
                in_valid = ($urandom_range(0, 3) != 0);
                if (phase == 0) begin
                    f1 = base + int'($urandom_range(0, 3));
                    f2 = base + int'($urandom_range(0, 3));
                    base += 3;
                end else begin
                    f1 = ($urandom_range(0, 15) == 0) ? FMIN : int'($urandom_range(0, 60)) - 30;
                    f2 = ($urandom_range(0, 15) == 0) ? FMIN : int'($urandom_range(0, 60)) - 30;
                end
                in_chrom1 = 8'($urandom);
                in_chrom2 = 8'($urandom);
                in_fit1   = 27'(f1);
                in_fit2   = 27'(f2);
                tick();
                for (int i = 0; i < NI; i++) begin
                    model_eval(i);
                    n_checks++;
                    if (o_best[i] !== e_best[i] || o_fit[i] !== 27'(e_fit[i]) ||
                        o_gen[i] !== 16'(e_gen[i]) || o_busy[i] !== e_busy[i] ||
                        o_done[i] !== e_done[i] || o_stalled[i] !== e_stalled[i]) begin
                        if (bad < 20)
                            $display("FAIL random[%0d] cyc %0d: got best=%0h fit=%0d gen=%0d busy=%0b done=%0b st=%0b, want %0h/%0d/%0d/%0b/%0b/%0b",
                                     i, cyc, o_best[i], o_fit[i], o_gen[i], o_busy[i], o_done[i], o_stalled[i],
                                     e_best[i], e_fit[i], e_gen[i], e_busy[i], e_done[i], e_stalled[i]);
                        bad++;
                    end else n_pass++;
                end
            end
            start = 1'b0;
            in_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_first_gen();
        test_tie();
        test_stall();
        test_max_gens();
        test_restart_in_done();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
